// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with one-outstanding IMEM reads
//
// Owns the fetch PC, issues word reads to instruction memory over req/gnt/rvalid,
// buffers the returned word and offers it to the decoder with valid/ready.
// A branch redirect kills any in-flight read or buffered instruction.
//
// Parameters:
//   RESET_PC         first fetch address after reset (word aligned)
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   o_imem_req       read request, held until i_imem_gnt
//   o_imem_addr      word address of the request
//   i_imem_gnt       request accepted this cycle
//   i_imem_rvalid    read data valid
//   i_imem_rdata     read data
//   o_id_valid       buffered instruction valid
//   i_id_ready       decoder consumes the instruction on valid & ready
//   o_id_instr       buffered instruction
//   o_id_pc4         address of o_id_instr + 4
//   o_op, o_funct    o_id_instr[31:26], o_id_instr[5:0]
//   i_branch         redirect pulse
//   i_branch_target  redirect address (low two bits ignored)
//   o_stall_cnt      cycles without a valid instruction, saturating
//                    (present only when FETCH_STALL_CNT_EN is defined)
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_id_valid,
    input  logic        i_id_ready,
    output logic [31:0] o_id_instr,
    output logic [31:0] o_id_pc4,
    output logic [5:0]  o_op,
    output logic [5:0]  o_funct,
    input  logic        i_branch,
    input  logic [31:0] i_branch_target
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0] o_stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_pc4;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc4;
    logic        r_id_valid;
    logic        w_accept;   // grant taken and not killed by a branch
    logic        w_capture;  // response lands in the buffer
    logic        w_release;  // buffer emptied (consumed or flushed)

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            S_IDLE: w_next_state = S_REQ;
            S_REQ: begin
                if (i_imem_gnt) begin
                    // A read granted in the same cycle as a branch is still
                    // outstanding in memory, so its response must be drained.
                    w_next_state = i_branch ? S_DROP : S_WAIT;
                    w_accept     = !i_branch;
                end
            end
            S_WAIT: begin
                if (i_imem_rvalid) begin
                    w_next_state = i_branch ? S_REQ : S_HOLD;
                    w_capture    = !i_branch;
                end else if (i_branch) begin
                    w_next_state = S_DROP;
                end
            end
            S_HOLD: begin
                // A branch flushes the buffer; if ready is also high the
                // decoder has taken the instruction, which is the same action.
                if (i_branch || i_id_ready) begin
                    w_next_state = S_REQ;
                    w_release    = 1'b1;
                end
            end
            S_DROP: begin
                if (i_imem_rvalid) begin
                    w_next_state = S_REQ;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_pc4  <= 32'h0;
            r_id_instr <= 32'h0;
            r_id_pc4   <= 32'h0;
            r_id_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (i_branch) begin
                r_fetch_pc <= {i_branch_target[31:2], 2'b00};
            end else if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_accept) begin
                r_req_pc4 <= r_fetch_pc + 32'd4;
            end
            if (w_capture) begin
                r_id_instr <= i_imem_rdata;
                r_id_pc4   <= r_req_pc4;
                r_id_valid <= 1'b1;
            end else if (w_release) begin
                r_id_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= 32'h0;
        end else if (!r_id_valid && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

    assign o_imem_req  = (r_state == S_REQ);
    assign o_imem_addr = r_fetch_pc;
    assign o_id_valid  = r_id_valid;
    assign o_id_instr  = r_id_instr;
    assign o_id_pc4    = r_id_pc4;
    assign o_op        = r_id_instr[31:26];
    assign o_funct     = r_id_instr[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req, gnt, rvalid, valid, ready, branch;
    logic [31:0] addr, rdata, instr, pc4, target;
    logic [5:0]  op, funct;

    logic        req1, valid1;
    logic [31:0] addr1, instr1, pc41;
    logic [5:0]  op1, funct1;
    logic        one1  = 1'b1;
    logic        zero1 = 1'b0;
    logic [31:0] rdata1 = 32'h0000_0020;
    logic [31:0] zero32 = 32'h0;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall, stall1;
`endif

    int errors = 0;
    int checks = 0;
    int hs_count = 0;

    fetch_stage dut (
        .i_clk(clk), .i_rst(rst),
        .o_imem_req(req), .o_imem_addr(addr), .i_imem_gnt(gnt),
        .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
        .o_id_valid(valid), .i_id_ready(ready), .o_id_instr(instr), .o_id_pc4(pc4),
        .o_op(op), .o_funct(funct), .i_branch(branch), .i_branch_target(target)
`ifdef FETCH_STALL_CNT_EN
        , .o_stall_cnt(stall)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .i_clk(clk), .i_rst(rst),
        .o_imem_req(req1), .o_imem_addr(addr1), .i_imem_gnt(one1),
        .i_imem_rvalid(one1), .i_imem_rdata(rdata1),
        .o_id_valid(valid1), .i_id_ready(one1), .o_id_instr(instr1), .o_id_pc4(pc41),
        .o_op(op1), .o_funct(funct1), .i_branch(zero1), .i_branch_target(zero32)
`ifdef FETCH_STALL_CNT_EN
        , .o_stall_cnt(stall1)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction memory contents as a pure function of address.
    bit mem_const;
    function automatic logic [31:0] mem(input logic [31:0] a);
        return mem_const ? 32'h0000_0020 : ({a[15:0], a[31:16]} ^ 32'h1357_9BDF);
    endfunction

    // Instruction memory responder: one outstanding read, configurable timing.
    bit tied, rand_timing;
    int gnt_dly_fix, lat_fix;
    initial begin
        bit          pend, g_now, rv_now;
        logic [31:0] g_addr, p_addr;
        int          p_wait, g_wait;
        gnt = 0; rvalid = 0; rdata = 0;
        pend = 0; g_now = 0; rv_now = 0; g_addr = 0; p_addr = 0; p_wait = 0; g_wait = -1;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                pend = 0; g_now = 0; rv_now = 0; g_wait = -1; gnt = 0; rvalid = 0;
            end else if (tied) begin
                gnt = 1; rvalid = 1; rdata = mem(addr);
            end else begin
                if (rv_now) pend = 0;
                if (g_now) begin
                    pend = 1; p_addr = g_addr;
                    p_wait = rand_timing ? int'($urandom_range(1, 3)) : lat_fix;
                end
                rv_now = 0; rvalid = 0; rdata = $urandom;
                if (pend) begin
                    p_wait--;
                    if (p_wait == 0) begin
                        rvalid = 1; rdata = mem(p_addr); rv_now = 1;
                    end
                end
                g_now = 0;
                gnt = rand_timing ? 1'($urandom_range(0, 1)) : 1'b0;
                if (req) begin
                    gnt = 0;
                    if (g_wait < 0) g_wait = rand_timing ? int'($urandom_range(0, 3)) : gnt_dly_fix;
                    if (g_wait == 0) begin
                        gnt = 1; g_now = 1; g_addr = addr; g_wait = -1;
                    end else begin
                        g_wait--;
                    end
                end
            end
        end
    end

    // Reference model + monitor: consumed instructions form a sequential stream
    // restarting at every redirect; granted addresses do likewise.
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc, exp_req_pc, e;
    logic        p_req, p_gnt, p_branch, p_valid, p_ready;
    logic [31:0] p_addr_m, p_instr, p_pc4;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_pc = 32'h0; exp_req_pc = 32'h0;
            p_req = 0; p_gnt = 0; p_branch = 0; p_valid = 0; p_ready = 0;
        end else begin
            if (p_req && !p_gnt && !p_branch) begin
                check("req_held", 32'(req), 1);
                check("addr_held", addr, p_addr_m);
            end
            if (p_valid && !p_ready && !p_branch) begin
                check("valid_held", 32'(valid), 1);
                check("instr_held", instr, p_instr);
                check("pc4_held", pc4, p_pc4);
            end
            if (valid) check("hold_no_req", 32'(req), 0);
            if (req && gnt) begin
                check("req_addr", addr, exp_req_pc);
                exp_req_pc = exp_req_pc + 32'd4;
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    exp_q.push_back(exp_pc);
                    exp_pc = exp_pc + 32'd4;
                end
                e = exp_q.pop_front();
                hs_count++;
                check("instr", instr, mem(e));
                check("pc4", pc4, e + 32'd4);
                check("op", 32'(op), 32'(instr[31:26]));
                check("funct", 32'(funct), 32'(instr[5:0]));
            end
            if (branch) begin
                exp_q.delete();
                exp_pc = {target[31:2], 2'b00};
                exp_req_pc = {target[31:2], 2'b00};
            end
        end
        p_req = req; p_gnt = gnt; p_branch = branch; p_valid = valid; p_ready = ready;
        p_addr_m = addr; p_instr = instr; p_pc4 = pc4;
    end

    task automatic step;
        @(posedge clk); #2;
    endtask

    task automatic do_reset(input bit t, input bit mc, input bit rt, input int gd, input int lat);
        rst = 1;
        tied = t; mem_const = mc; rand_timing = rt; gnt_dly_fix = gd; lat_fix = lat;
        branch = 0;
        repeat (2) @(posedge clk);
        #2;
        rst = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"}, 32'(req), 0);
        check({tag, "_addr"}, addr, 32'h0);
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_instr"}, instr, 32'h0);
        check({tag, "_pc4"}, pc4, 32'h0);
        check({tag, "_op"}, 32'(op), 0);
        check({tag, "_funct"}, 32'(funct), 0);
`ifdef FETCH_STALL_CNT_EN
        check({tag, "_stall"}, stall, 32'h0);
`endif
    endtask

    task automatic wait_grant(output bit ok);
        ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (req && gnt) ok = 1;
            else step();
        end
        check("grant_timeout", 32'(ok), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a_addr[$], a_pc4[$], a1_addr[$], a1_pc4[$], a0;
        int          vcyc[$];
        int          n;
        bit          ok, saw_valid;

        rst = 1; ready = 0; branch = 0; target = 0;
        tied = 1; mem_const = 1; rand_timing = 0; gnt_dly_fix = 0; lat_fix = 1;

        // Reset values, then free-running fetch with GNT/RVALID tied high.
        ready = 1;
        do_reset(1, 1, 0, 0, 1);
        check_reset_vals("rst");
        check("rst1_addr", addr1, 32'hFFFF_FFFC);
        for (int k = 0; k < 12; k++) begin
            if (req) a_addr.push_back(addr);
            if (valid) begin
                a_pc4.push_back(pc4);
                vcyc.push_back(k);
                if (vcyc.size() == 1) begin
                    check("tied_op", 32'(op), 0);
                    check("tied_funct", 32'(funct), 32'h20);
                end
            end
            if (req1) a1_addr.push_back(addr1);
            if (valid1) a1_pc4.push_back(pc41);
            step();
        end
        check("tied_valid_count", 32'(vcyc.size()), 3);
        check("tied_req_count", 32'(a_addr.size()), 4);
        for (int k = 0; k < 3; k++) begin
            if (k < vcyc.size()) check("tied_valid_cycle", 32'(vcyc[k]), 32'(3 * k + 3));
            if (k < a_addr.size()) check("tied_addr", a_addr[k], 32'(4 * k));
            if (k < a_pc4.size()) check("tied_pc4", a_pc4[k], 32'(4 * k + 4));
        end
        check("wrap_req_count", 32'(a1_addr.size()), 4);
        if (a1_addr.size() >= 2) begin
            check("wrap_addr0", a1_addr[0], 32'hFFFF_FFFC);
            check("wrap_addr1", a1_addr[1], 32'h0);
        end
        check("wrap_pc4_count", 32'(a1_pc4.size()), 3);
        if (a1_pc4.size() >= 1) check("wrap_pc4", a1_pc4[0], 32'h0);

        // Decoder stalls: buffered instruction held, no new request.
        ready = 0;
        do_reset(1, 1, 0, 0, 1);
        saw_valid = 0;
        for (int k = 0; k < 20 && !saw_valid; k++) begin
            if (valid) saw_valid = 1;
            else step();
        end
        check("hold_valid_timeout", 32'(saw_valid), 1);
        for (int k = 0; k < 10; k++) begin
            check("hold_valid", 32'(valid), 1);
            check("hold_req", 32'(req), 0);
            check("hold_instr", instr, 32'h20);
            check("hold_pc4", pc4, 32'h4);
`ifdef FETCH_STALL_CNT_EN
            check("hold_stall_cnt", stall, 32'd3);
`endif
            step();
        end
        ready = 1;

        // Grant delayed by 3 cycles.
        do_reset(0, 0, 0, 3, 1);
        n = 0;
        for (int k = 0; k < 10 && !req; k++) step();
        a0 = addr;
        while (req && !gnt && n < 20) begin
            n++;
            step();
        end
        check("gdly_wait_cycles", 32'(n), 3);
        check("gdly_granted", 32'(req && gnt), 1);
        check("gdly_addr", addr, a0);
        check("gdly_addr0", a0, 32'h0);

        // Branch while waiting; response arrives 2 cycles later and is dropped.
        do_reset(0, 0, 0, 0, 3);
        wait_grant(ok);
        step();
        branch = 1; target = 32'h0000_0103;
        step();
        branch = 0;
        saw_valid = 0;
        for (int k = 0; k < 6 && !req; k++) begin
            if (valid) saw_valid = 1;
            step();
        end
        check("br_no_valid", 32'(saw_valid || valid), 0);
        check("br_req", 32'(req), 1);
        check("br_addr", addr, 32'h0000_0100);

        // Reset in the middle of a read.
        do_reset(0, 0, 0, 0, 3);
        wait_grant(ok);
        step();
        rst = 1;
        step();
        check_reset_vals("midrst");
        rst = 0;

        // Randomised traffic with redirects.
        do_reset(0, 0, 1, 0, 1);
        for (int k = 0; k < 3000; k++) begin
            ready = ($urandom_range(0, 2) != 0);
            if (!branch && ($urandom_range(0, 9) == 0)) begin
                branch = 1;
                target = $urandom;
            end else begin
                branch = 0;
            end
            step();
        end
        branch = 0;
        step();
        check("rand_handshakes", 32'(hs_count > 200), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
